// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_flash_responder_if                                          |
// | Brief  : Single-bit SPI pin bundle between a controller and flash target |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface spi_flash_responder_if;
  logic spi_sck;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso_o;
  logic spi_miso_en;

  modport master (
    output spi_sck,
    output spi_csn,
    output spi_mosi,
    input  spi_miso_o,
    input  spi_miso_en
  );

  modport slave (
    input  spi_sck,
    input  spi_csn,
    input  spi_mosi,
    output spi_miso_o,
    output spi_miso_en
  );
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_flash_responder                                             |
// | Brief  : Mode-0 SPI flash-style target serving a small byte memory       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_flash_responder #(
  parameter int          MEM_AW      = 8,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  spi_flash_responder_if.slave spi,
  output logic                 status_wel
);

  localparam int                c_depth = 2 ** MEM_AW;
  localparam logic [MEM_AW-1:0] c_one   = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_STAT, S_ID, S_IGNORE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_csn_sync, r_mosi_sync;
  logic                   r_sck_prev, r_csn_prev;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_byte_cnt;
  logic [6:0]             r_shift_in;
  logic [7:0]             r_miso_sr;
  logic [MEM_AW-1:0]      r_addr;
  logic                   r_is_read, r_pend_wren, r_pend_wrdi, r_wdata_seen;
  logic                   r_wel, r_miso_o, r_miso_en;
  logic [7:0]             r_mem [c_depth];

  logic              w_sck_s, w_csn_s, w_mosi_s;
  logic              w_csn_rise, w_csn_fall, w_rise_act, w_fall_act;
  logic              w_byte_done, w_mem_we, w_shift_state;
  logic [7:0]        w_byte_in, w_load;
  logic [MEM_AW-1:0] w_addr_nxt;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_csn_s  = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // CSN edges take priority: any SCK edge coinciding with them is dropped.
  assign w_csn_rise  = w_csn_s & ~r_csn_prev;
  assign w_csn_fall  = ~w_csn_s & r_csn_prev;
  assign w_rise_act  = w_sck_s & ~r_sck_prev & ~w_csn_rise & ~w_csn_fall & (r_state != S_IDLE);
  assign w_fall_act  = ~w_sck_s & r_sck_prev & ~w_csn_rise & ~w_csn_fall & (r_state != S_IDLE);
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_byte_in   = {r_shift_in, w_mosi_s};
  assign w_mem_we    = w_rise_act & w_byte_done & (r_state == S_WDATA) & r_wel;
  assign w_shift_state = (r_state == S_RDATA) | (r_state == S_STAT) | (r_state == S_ID);

  // Only the low MEM_AW bits of the 24-bit address are retained.
  if (MEM_AW <= 8) begin : g_addr_narrow
    assign w_addr_nxt = w_byte_in[MEM_AW-1:0];
  end else begin : g_addr_wide
    assign w_addr_nxt = {r_addr[MEM_AW-9:0], w_byte_in};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sck_sync  <= '0;
      r_csn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi.spi_csn};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      r_sck_prev  <= w_sck_s;
      r_csn_prev  <= w_csn_s;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_csn_rise) begin
      w_state_nxt = S_IDLE;
    end else if (w_csn_fall) begin
      w_state_nxt = S_CMD;
    end else if (w_rise_act && w_byte_done) begin
      case (r_state)
        S_CMD: begin
          case (w_byte_in)
            8'h03, 8'h02: w_state_nxt = S_ADDR;
            8'h05:        w_state_nxt = S_STAT;
            8'h9F:        w_state_nxt = S_ID;
            default:      w_state_nxt = S_IGNORE;
          endcase
        end
        S_ADDR:  if (r_byte_cnt == 2'd2) w_state_nxt = r_is_read ? S_RDATA : S_WDATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_load = 8'h00;
    case (r_state)
      S_RDATA: w_load = r_mem[r_addr];
      S_STAT:  w_load = {6'b0, r_wel, 1'b0};
      S_ID: begin
        case (r_byte_cnt)
          2'd0:    w_load = JEDEC_ID[23:16];
          2'd1:    w_load = JEDEC_ID[15:8];
          2'd2:    w_load = JEDEC_ID[7:0];
          default: w_load = 8'h00;
        endcase
      end
      default: w_load = 8'h00;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 2'd0;
      r_shift_in   <= 7'd0;
      r_miso_sr    <= 8'd0;
      r_addr       <= '0;
      r_is_read    <= 1'b0;
      r_pend_wren  <= 1'b0;
      r_pend_wrdi  <= 1'b0;
      r_wdata_seen <= 1'b0;
      r_wel        <= 1'b0;
      r_miso_o     <= 1'b0;
      r_miso_en    <= 1'b0;
    end else begin
      r_miso_en <= (w_state_nxt == S_RDATA) | (w_state_nxt == S_STAT) | (w_state_nxt == S_ID);
      if (w_csn_rise) begin
        // A pending WREN/WRDI survives only if no bit followed the opcode.
        if (r_pend_wren)  r_wel <= 1'b1;
        if (r_pend_wrdi)  r_wel <= 1'b0;
        if (r_wdata_seen) r_wel <= 1'b0;
        r_bit_cnt    <= 3'd0;
        r_pend_wren  <= 1'b0;
        r_pend_wrdi  <= 1'b0;
        r_wdata_seen <= 1'b0;
      end else if (w_csn_fall) begin
        r_bit_cnt    <= 3'd0;
        r_byte_cnt   <= 2'd0;
        r_pend_wren  <= 1'b0;
        r_pend_wrdi  <= 1'b0;
        r_wdata_seen <= 1'b0;
      end else begin
        if (w_rise_act) begin
          r_shift_in <= w_byte_in[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_state == S_IGNORE) begin
            r_pend_wren <= 1'b0;
            r_pend_wrdi <= 1'b0;
          end
          if (w_byte_done) begin
            case (r_state)
              S_CMD: begin
                r_is_read   <= (w_byte_in == 8'h03);
                r_byte_cnt  <= 2'd0;
                r_pend_wren <= (w_byte_in == 8'h06);
                r_pend_wrdi <= (w_byte_in == 8'h04);
              end
              S_ADDR: begin
                r_addr     <= w_addr_nxt;
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd2 && !r_is_read) r_wdata_seen <= 1'b1;
              end
              S_RDATA, S_WDATA: r_addr <= r_addr + c_one;
              S_ID: if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
              default: r_addr <= r_addr;
            endcase
          end
        end
        // Falling edge at a byte boundary loads a fresh byte; otherwise shift.
        if (w_fall_act && w_shift_state) begin
          if (r_bit_cnt == 3'd0) begin
            r_miso_o  <= w_load[7];
            r_miso_sr <= {w_load[6:0], 1'b0};
          end else begin
            r_miso_o  <= r_miso_sr[7];
            r_miso_sr <= {r_miso_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= 8'hFF;
    end else if (w_mem_we) begin
      r_mem[r_addr] <= w_byte_in;
    end
  end

  assign spi.spi_miso_o  = r_miso_o;
  assign spi.spi_miso_en = r_miso_en;
  assign status_wel      = r_wel;

endmodule
`default_nettype wire
